// File: rtl/sync_rom_pkg.sv
// rtl/sync_rom_pkg.sv - shared widths, types and default contents for sync_rom
package sync_rom_pkg;

    localparam int ROM_ADDR_W = 4;
    localparam int ROM_DATA_W = 4;

    typedef logic [ROM_ADDR_W-1:0] rom_addr_t;
    typedef logic [ROM_DATA_W-1:0] rom_word_t;

    // Word i holds ~i; listed from address 0 upward.
    localparam rom_word_t ROM_INIT [2**ROM_ADDR_W] = '{
        4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
        4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0
    };

endpackage

// File: rtl/sync_rom.sv
// rtl/sync_rom.sv - registered-output constant lookup table with read enable
// Optional simulation X-check: SYNC_ROM_XCHECK_EN
module sync_rom
    import sync_rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W,
    parameter logic [DATA_W-1:0] INIT [2**ADDR_W] = ROM_INIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              data_valid
);

    // data holds across disabled cycles; only data_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data       <= '0;
            data_valid <= 1'b0;
        end else if (en) begin
`ifdef SYNC_ROM_XCHECK_EN
            if ($isunknown(addr)) begin
                $error("sync_rom: X/Z on addr during enabled read at time %0t", $time);
                data <= 'x;
            end else begin
                data <= INIT[addr];
            end
`else
            data <= INIT[addr];
`endif
            data_valid <= 1'b1;
        end else begin
            data_valid <= 1'b0;
        end
    end

`ifdef SYNC_ROM_XCHECK_EN
    always @(posedge clk) begin
        if (rst_n === 1'b1 && $isunknown(en))
            $error("sync_rom: X/Z on en at time %0t", $time);
    end
`endif

endmodule

// File: tb/tb_sync_rom.sv
// tb/tb_sync_rom.sv - table-driven scoreboard bench for sync_rom
module tb_sync_rom;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] addr;
    logic [3:0] data;
    logic       data_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] addr;
        logic [3:0] exp_data;
        logic       exp_valid;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] exp_data;
        logic       exp_valid;
    } exp_t;

    vec_t vecs [11];
    exp_t sb [$];
    logic [3:0] model_data;

    sync_rom dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .addr       (addr),
        .data       (data),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    task automatic drive(input string name, input logic r, input logic e,
                         input logic [3:0] a, input logic [3:0] ed, input logic ev);
        exp_t x;
        rst_n = r;
        en    = e;
        addr  = a;
        x.name = name;
        x.exp_data = ed;
        x.exp_valid = ev;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        checks++;
        if (data !== x.exp_data || data_valid !== x.exp_valid) begin
            errors++;
            $display("FAIL %s: got data=%h valid=%b, expected data=%h valid=%b",
                     x.name, data, data_valid, x.exp_data, x.exp_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        addr  = 4'h0;

        vecs[0]  = '{1'b0, 1'b1, 4'hA, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'hA, 4'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'hA, 4'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'hA, 4'h5, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 4'h6, 4'h9, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 4'h3, 4'hC, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 4'hF, 4'hC, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'hF, 4'hC, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4'h8, 4'h7, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 4'h0, 4'hF, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 4'hF, 4'h0, 1'b1};

        @(negedge clk);
        for (int i = 0; i < 11; i++)
            drive($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].en, vecs[i].addr,
                  vecs[i].exp_data, vecs[i].exp_valid);

        // Exhaustive sweep with a reset pulse injected mid-way.
        model_data = 4'h0;
        for (int i = 0; i < 17; i++) begin
            logic [3:0] a;
            a = (i < 8) ? 4'(i) : 4'(i - 1);
            if (i == 8) begin
                model_data = 4'h0;
                drive("sweep_rst", 1'b0, 1'b1, 4'h5, 4'h0, 1'b0);
            end else begin
                model_data = ~a;
                drive($sformatf("sweep%0d", a), 1'b1, 1'b1, a, model_data, 1'b1);
            end
        end
        drive("sweep_hold", 1'b1, 1'b0, 4'h3, model_data, 1'b0);

`ifdef SYNC_ROM_XCHECK_EN
        drive("x_hold", 1'b1, 1'b0, 4'bxxxx, model_data, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;
        addr  = 4'bxxxx;
        @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b1) begin
            errors++;
            $display("FAIL x_read_valid: got %b, expected 1", data_valid);
        end
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
